ram_lsu: RTL and testbench
==========================

Name: ram_lsu

Overview:
- Byte-serial load/store initiator that sits between the picoRISC pipeline MEM stage and the byte-wide synchronous data RAM.
- Converts one byte, half or word access from the pipeline into a sequence of single-byte RAM accesses.
- Drives the RAM write strobe, 8-bit address and write byte, and assembles read bytes into a little-endian word.
- Stalls the pipeline through busy until the access completes.

Parameters:
- n, 32, pipeline word width in bits; must be a multiple of 8; NB = n/8 byte lanes.
- MEM_DEPTH, 200, number of implemented RAM bytes; used only when the optional feature is compiled in.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  1  access request; held by the pipeline until done.
- we  in  1  1 = store, 0 = load; sampled at accept.
- size  in  2  00 = byte, 01 = half, 10 = word, 11 = word.
- addr  in  8  byte base address; sampled at accept.
- wdata  in  n  store data; byte i goes to addr+i.
- busy  out  1  access in progress; pipeline stalls.
- done  out  1  one-cycle completion pulse.
- err  out  1  range error, pulsed together with done.
- rdata  out  n  assembled load data, zero-extended; held between loads.
- ram_sw  out  1  RAM write strobe.
- ram_addr  out  8  RAM byte address.
- ram_din  out  8  RAM write byte.
- ram_dout  in  8  RAM read byte; registered in the RAM, valid one cycle after ram_addr.

Behaviour:
- Byte count k: 1, 2 or min(4,NB) for size 00, 01 and 10/11.
- Byte addresses are addr+i mod 256, for i = 0..k-1.
- States: IDLE, STORE, LOAD, LAST, DONE.
- busy = 1 in STORE, LOAD and LAST; done = 1 only in DONE.
- Accept:
  - req is accepted on an edge where state is IDLE or DONE.
  - On accept, latch we, size, addr and wdata, and clear the byte index.
  - Go to STORE if we = 1, otherwise LOAD.
  - req in any other state is ignored.
- STORE:
  - ram_sw = 1, ram_addr = base+i, ram_din = wdata[8i+:8].
  - i increments each cycle; after byte k-1, go to DONE.
  - Bytes above k-1 are never written.
  - Done arrives in cycle k+1 after the accept edge.
- LOAD:
  - ram_sw = 0, ram_addr = base+i.
  - From i = 1 on, capture ram_dout into shadow[8(i-1)+:8].
  - After byte k-1 is issued, go to LAST.
- LAST: capture ram_dout into shadow byte k-1, then go to DONE.
  - Load done arrives in cycle k+2.
- DONE (one cycle):
  - After a load, rdata = shadow with bytes k..NB-1 forced to 0.
  - After a store, rdata is unchanged.
  - Next state is IDLE, or STORE/LOAD if a new req is accepted.
- Outside STORE: ram_sw = 0 and ram_din = 0. In IDLE and DONE: ram_addr = 0.
- Reset values: state IDLE, busy 0, done 0, err 0, rdata 0, shadow 0, ram_sw 0, ram_addr 0, ram_din 0.
- Reset mid-operation: abort immediately with no further ram_sw and no done. Bytes already written stay in RAM.
- Wrap: base FF, size word gives addresses FF, 00, 01, 02 (no error when the optional feature is out).

Optional Feature:
- Macro: RAM_LSU_RANGE_CHECK_EN.
- With it:
  - At accept, compute the unwrapped 9-bit end address addr+k-1.
  - If the end address is ≥ MEM_DEPTH, go directly to DONE with err = 1.
  - No RAM strobes are issued and rdata is unchanged; done arrives in cycle 1 after accept.
- Without it: err is tied to 0 and addresses wrap mod 256.

Decomposition:
- Package picorisc_mem_pkg holds:
  - size_t enum (SZ_BYTE, SZ_HALF, SZ_WORD);
  - lsu_state_t enum;
  - RAM_ADDR_W = 8;
  - RAM_DEPTH_DEFAULT = 200.
- No sub-module: the single FSM plus counter, shadow register and byte mux.

Test Plan:
- Reset, then idle for 5 cycles -> busy, done, ram_sw, rdata, err all 0; ram_addr 0.
- Store word DEADBEEF to 10 -> ram_sw = 1 for 4 cycles, addr/din 10/EF, 11/BE, 12/AD, 13/DE; done in cycle 5.
- After that store, load word from 10 -> rdata = DEADBEEF, done in cycle 6; load byte from 12 -> rdata = 000000AD, done in cycle 3.
- Load half at FF with RAM[FF] = 34 and RAM[00] = 12 -> addresses FF then 00; rdata = 00001234.
- Back-to-back: req held high through DONE with a new store -> new access starts on the DONE edge, no idle cycle. Reset asserted during the second STORE byte -> only the first byte is written and no done.
- With RAM_LSU_RANGE_CHECK_EN: word access at C6 (end C9 ≥ 200) -> err = 1 and done in cycle 1, no ram_sw. Word at C4 (end C7) -> normal access, err = 0.

Source files
------------

// File: rtl/picorisc_mem_pkg.sv
// Shared types and constants for the picoRISC byte-serial data memory path.
package picorisc_mem_pkg;

  localparam int RAM_ADDR_W        = 8;
  localparam int RAM_DEPTH_DEFAULT = 200;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STORE,
    ST_LOAD,
    ST_LAST,
    ST_DONE
  } lsu_state_t;

  // Bytes moved for an access size, clamped to the lanes the pipeline word has.
  function automatic int byte_count(input logic [1:0] size, input int nb);
    int k;
    case (size_t'(size))
      SZ_BYTE: k = 1;
      SZ_HALF: k = 2;
      default: k = 4;
    endcase
    if (k > nb) k = nb;
    return k;
  endfunction

endpackage

// File: rtl/ram_lsu.sv
// Byte-serial load/store initiator between the MEM stage and a byte-wide synchronous RAM.
// Optional end-address range check is compiled in with `define RAM_LSU_RANGE_CHECK_EN.
module ram_lsu
  import picorisc_mem_pkg::*;
#(
  parameter int n         = 32,
  parameter int MEM_DEPTH = RAM_DEPTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  we,
  input  logic [1:0]            size,
  input  logic [7:0]            addr,
  input  logic [n-1:0]          wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [n-1:0]          rdata,
  output logic                  ram_sw,
  output logic [RAM_ADDR_W-1:0] ram_addr,
  output logic [7:0]            ram_din,
  input  logic [7:0]            ram_dout
);

  localparam int NB = n / 8;
  localparam int IW = $clog2(NB + 1);

  lsu_state_t      state_reg, state_next;
  logic [IW-1:0]   idx_reg, idx_next;
  logic [IW-1:0]   k_reg, k_in;
  logic [7:0]      base_reg;
  logic [n-1:0]    wdata_reg;
  logic            accept;
  logic            last_byte;
  logic [7:0]      wbyte    [NB];
  logic [7:0]      shadow_reg [NB];
  logic [7:0]      rdata_reg  [NB];

  assign k_in      = IW'(byte_count(size, NB));
  assign last_byte = (idx_reg == k_reg - 1'b1);

`ifdef RAM_LSU_RANGE_CHECK_EN
  logic [8:0] end_addr;
  logic       range_bad;
  logic       err_reg;

  // End address is computed unwrapped so an access running past FF is also caught.
  assign end_addr  = {1'b0, addr} + 9'(k_in) - 9'd1;
  assign range_bad = int'(end_addr) >= MEM_DEPTH;
  assign err       = (state_reg == ST_DONE) && err_reg && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_reg <= 1'b0;
    end else if (accept) begin
      err_reg <= range_bad;
    end
  end
`else
  assign err = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    accept     = 1'b0;
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        state_next = ST_IDLE;
        if (req) begin
          accept     = 1'b1;
          idx_next   = '0;
          state_next = we ? ST_STORE : ST_LOAD;
`ifdef RAM_LSU_RANGE_CHECK_EN
          if (range_bad) state_next = ST_DONE;
`endif
        end
      end
      ST_STORE: begin
        idx_next = idx_reg + 1'b1;
        if (last_byte) state_next = ST_DONE;
      end
      ST_LOAD: begin
        idx_next = idx_reg + 1'b1;
        if (last_byte) state_next = ST_LAST;
      end
      ST_LAST: state_next = ST_DONE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      idx_reg   <= '0;
      k_reg     <= '0;
      base_reg  <= '0;
      wdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      if (accept) begin
        k_reg     <= k_in;
        base_reg  <= addr;
        wdata_reg <= wdata;
      end
    end
  end

  // Strobe and done are gated by reset so an abort takes effect in the same cycle.
  assign busy     = (state_reg == ST_STORE) || (state_reg == ST_LOAD) || (state_reg == ST_LAST);
  assign done     = (state_reg == ST_DONE) && !reset;
  assign ram_sw   = (state_reg == ST_STORE) && !reset;
  assign ram_addr = ((state_reg == ST_STORE) || (state_reg == ST_LOAD))
                    ? base_reg + RAM_ADDR_W'(idx_reg) : '0;
  assign ram_din  = (state_reg == ST_STORE) ? wbyte[idx_reg] : '0;

  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    assign wbyte[gi]           = wdata_reg[8*gi +: 8];
    assign rdata[8*gi +: 8]    = rdata_reg[gi];

    // RAM read data lags the address by one cycle, so lane gi arrives when idx is gi+1.
    always_ff @(posedge clk) begin
      if (reset) begin
        shadow_reg[gi] <= '0;
        rdata_reg[gi]  <= '0;
      end else begin
        if (((state_reg == ST_LOAD) || (state_reg == ST_LAST)) && (int'(idx_reg) == gi + 1)) begin
          shadow_reg[gi] <= ram_dout;
        end
        if (state_reg == ST_LAST) begin
          if (int'(k_reg) == gi + 1) begin
            rdata_reg[gi] <= ram_dout;
          end else if (gi < int'(k_reg)) begin
            rdata_reg[gi] <= shadow_reg[gi];
          end else begin
            rdata_reg[gi] <= '0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_lsu.sv
// Randomized bench for ram_lsu against a byte-array reference of the RAM; honours RAM_LSU_RANGE_CHECK_EN.
module tb_ram_lsu;

  localparam int N     = 32;
  localparam int DEPTH = 200;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [7:0]  addr = 8'h00;
  logic [N-1:0] wdata = '0;
  logic        busy, done, err;
  logic [N-1:0] rdata;
  logic        ram_sw;
  logic [7:0]  ram_addr, ram_din, ram_dout;

  ram_lsu #(.n(N), .MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .addr(addr),
    .wdata(wdata), .busy(busy), .done(done), .err(err), .rdata(rdata),
    .ram_sw(ram_sw), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // Byte-wide synchronous RAM with registered read.
  logic [7:0] mem [256];
  logic       fill = 1'b0;

  function automatic logic [7:0] pat(input int i);
    return 8'((i * 37 + 5) & 255);
  endfunction

  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < 256; i++) mem[i] <= pat(i);
    end else if (ram_sw) begin
      mem[ram_addr] <= ram_din;
    end
    ram_dout <= mem[ram_addr];
  end

  logic [7:0]  ref_mem [256];
  logic [31:0] rdata_model = '0;
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, expv);
    end
  endtask

  // Called at a negedge; returns at the negedge of the completion cycle with req dropped.
  task automatic access(input logic w, input logic [1:0] sz, input logic [7:0] a, input logic [31:0] d);
    int k, exp_done, wi, done_c, busy_c;
    bit bad;
    logic [7:0]  wa[$];
    logic [7:0]  wd[$];
    logic [31:0] exp_r;
    k = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    bad = 1'b0;
`ifdef RAM_LSU_RANGE_CHECK_EN
    bad = (int'(a) + k - 1 >= DEPTH);
`endif
    exp_r = rdata_model;
    if (bad) begin
      exp_done = 1;
    end else if (w) begin
      for (int i = 0; i < k; i++) begin
        wa.push_back(8'(int'(a) + i));
        wd.push_back(d[8*i +: 8]);
        ref_mem[8'(int'(a) + i)] = d[8*i +: 8];
      end
      exp_done = k + 1;
    end else begin
      exp_r = '0;
      for (int i = 0; i < k; i++) exp_r |= 32'(ref_mem[8'(int'(a) + i)]) << (8 * i);
      exp_done = k + 2;
      rdata_model = exp_r;
    end

    req = 1'b1; we = w; size = sz; addr = a; wdata = d;
    @(negedge clk);
    wi = 0; done_c = 0; busy_c = 0;
    for (int c = 1; c <= 20; c++) begin
      if (ram_sw) begin
        if (wi < wa.size()) begin
          check("wr_addr", 32'(ram_addr), 32'(wa[wi]));
          check("wr_data", 32'(ram_din), 32'(wd[wi]));
        end
        wi++;
      end
      if (busy) busy_c++;
      if (done) begin
        done_c = c;
        break;
      end
      @(negedge clk);
    end
    req = 1'b0;
    check("done_cycle", done_c, exp_done);
    check("busy_cycles", busy_c, exp_done - 1);
    check("n_writes", wi, wa.size());
    check("rdata", rdata, exp_r);
    check("err", 32'(err), 32'(bad));
    $display("txn %s size=%0d addr=%02h wdata=%08h rdata=%08h err=%0b done@%0d",
             w ? "ST" : "LD", sz, a, d, rdata, err, done_c);
  endtask

  initial begin
    int bad_bytes;
    for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
    reset = 1'b1;
    fill  = 1'b1;
    repeat (3) @(negedge clk);
    fill  = 1'b0;
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_sw", 32'(ram_sw), 0);
    check("rst_rdata", rdata, 0);
    check("rst_err", 32'(err), 0);
    check("rst_addr", 32'(ram_addr), 0);
    check("rst_din", 32'(ram_din), 0);

    access(1'b1, 2'd2, 8'h10, 32'hDEADBEEF);
    @(negedge clk);
    access(1'b0, 2'd2, 8'h10, 32'h0);
    check("ld_word", rdata, 32'hDEADBEEF);
    access(1'b0, 2'd0, 8'h12, 32'h0);
    check("ld_byte", rdata, 32'h000000AD);
    access(1'b1, 2'd0, 8'hFF, 32'h34);
    access(1'b1, 2'd0, 8'h00, 32'h12);
    @(negedge clk);
    access(1'b0, 2'd1, 8'hFF, 32'h0);
    check("ld_half_wrap", rdata, 32'h00001234);
    access(1'b0, 2'd3, 8'hFF, 32'h0);
`ifdef RAM_LSU_RANGE_CHECK_EN
    access(1'b0, 2'd2, 8'hC6, 32'h0);
    access(1'b1, 2'd2, 8'hC6, 32'h01020304);
    access(1'b0, 2'd2, 8'hC4, 32'h0);
`endif

    for (int t = 0; t < 150; t++) begin
      if ($urandom_range(0, 2) == 0) @(negedge clk);
      access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom), $urandom);
    end

    // Back-to-back store, then reset during the second byte of the follow-up store.
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'd0; addr = 8'h40; wdata = 32'h11;
    @(negedge clk);
    check("b2b_first_sw", 32'(ram_sw), 1);
    @(negedge clk);
    check("b2b_first_done", 32'(done), 1);
    ref_mem[8'h40] = 8'h11;
    size = 2'd2; addr = 8'h50; wdata = 32'hA1B2C3D4;
    @(negedge clk);
    check("b2b_sw", 32'(ram_sw), 1);
    check("b2b_addr", 32'(ram_addr), 32'h50);
    check("b2b_din", 32'(ram_din), 32'hD4);
    ref_mem[8'h50] = 8'hD4;
    @(negedge clk);
    reset = 1'b1;
    req   = 1'b0;
    #1;
    check("abort_sw", 32'(ram_sw), 0);
    check("abort_done", 32'(done), 0);
    @(negedge clk);
    reset = 1'b0;
    rdata_model = '0;
    check("abort_busy", 32'(busy), 0);
    check("abort_rdata", rdata, rdata_model);
    for (int c = 0; c < 3; c++) begin
      check("abort_no_done", 32'(done), 0);
      @(negedge clk);
    end
    check("abort_byte0", 32'(mem[8'h50]), 32'hD4);
    check("abort_byte1", 32'(mem[8'h51]), 32'(ref_mem[8'h51]));
    $display("txn ST-abort size=2 addr=50 wdata=A1B2C3D4 reset on byte 1");

    bad_bytes = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad_bytes++;
    check("ram_image", bad_bytes, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
